// File: rtl/adc_pkg.sv
// Shared ADC-path definitions: sample width, averager defaults and the
// averager mode state encoding.
package adc_pkg;
  localparam int ADC_WIDTH           = 12;
  localparam int LOG2_N_DEF          = 4;
  localparam int DEBOUNCE_CYCLES_DEF = 50000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } avg_state_t;
endpackage

// File: rtl/sample_averager_if.sv
// Sample-in / average-out bundle between the ADC front end and the averager.
interface sample_averager_if;
  import adc_pkg::*;

  logic                 avg_sw;
  logic [ADC_WIDTH-1:0] meas_value;
  logic                 meas_valid;
  logic                 average_enable;
  logic [ADC_WIDTH-1:0] acumul_value;
  logic                 acumul_valid;

  modport master (
    output avg_sw, meas_value, meas_valid,
    input  average_enable, acumul_value, acumul_valid
  );

  modport slave (
    input  avg_sw, meas_value, meas_valid,
    output average_enable, acumul_value, acumul_valid
  );
endinterface

// File: rtl/switch_debouncer.sv
// Two-flop synchronizer followed by a stability counter for a raw board switch.
module switch_debouncer
  import adc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_raw,
  output logic sw_db
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             r_sync_p0;
  logic             r_sync_p1;
  logic             r_db;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync_p0 <= 1'b0;
      r_sync_p1 <= 1'b0;
      r_db      <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync_p0 <= sw_raw;
      r_sync_p1 <= r_sync_p0;
      // Any cycle where the synchronized level agrees with the output restarts the count
      if (r_sync_p1 != r_db) begin
        if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          r_db  <= r_sync_p1;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign sw_db = r_db;
endmodule

// File: rtl/sample_averager.sv
// Block averager: sums 2^LOG2_N ADC samples while the debounced mode switch is on
// and emits the round-half-up mean one cycle after the last sample.
module sample_averager
  import adc_pkg::*;
#(
  parameter int LOG2_N          = LOG2_N_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  sample_averager_if.slave  bus
);
  localparam int                ACC_W = ADC_WIDTH + LOG2_N;
  localparam logic [ACC_W-1:0]  HALF  = {{(ACC_W-1){1'b0}}, 1'b1} << (LOG2_N - 1);

  function automatic logic [ADC_WIDTH-1:0] round_avg(input logic [ACC_W-1:0] sum);
    logic [ACC_W-1:0] biased;
    // N*4095 + N/2 < 2^ACC_W, so the biased sum cannot wrap
    biased = sum + HALF;
    return biased[ACC_W-1:LOG2_N];
  endfunction

  logic                 w_mode_db;
  avg_state_t           r_state;
  avg_state_t           w_state_nxt;
  logic                 w_accept;
  logic                 w_last;
  logic                 w_leave;
  logic [ACC_W-1:0]     w_sum;

  logic [ACC_W-1:0]     r_acc_p0;
  logic [LOG2_N-1:0]    r_cnt_p0;
  logic [ADC_WIDTH-1:0] r_acumul_value_p1;
  logic                 r_acumul_valid_p1;

  switch_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_switch_debouncer (
    .clk    (clk),
    .rst_n  (rst_n),
    .sw_raw (bus.avg_sw),
    .sw_db  (w_mode_db)
  );

  // A falling mode switch takes priority over a sample arriving in the same cycle
  assign w_leave  = (r_state != ST_IDLE) && !w_mode_db;
  assign w_accept = bus.meas_valid && (r_state != ST_IDLE) && w_mode_db;
  assign w_last   = w_accept && (r_cnt_p0 == {LOG2_N{1'b1}});
  assign w_sum    = r_acc_p0 + {{LOG2_N{1'b0}}, bus.meas_value};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_mode_db) w_state_nxt = ST_FILL;
      ST_FILL: begin
        if (!w_mode_db)  w_state_nxt = ST_IDLE;
        else if (w_last) w_state_nxt = ST_RUN;
      end
      ST_RUN:  if (!w_mode_db) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Stage p0: running sum and sample count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc_p0 <= '0;
      r_cnt_p0 <= '0;
    end else if (w_leave || (r_state == ST_IDLE) || w_last) begin
      r_acc_p0 <= '0;
      r_cnt_p0 <= '0;
    end else if (w_accept) begin
      r_acc_p0 <= w_sum;
      r_cnt_p0 <= r_cnt_p0 + 1'b1;
    end
  end

  // Stage p1: rounded average and its one-cycle strobe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acumul_value_p1 <= '0;
      r_acumul_valid_p1 <= 1'b0;
    end else begin
      r_acumul_valid_p1 <= w_last;
      if (w_last) r_acumul_value_p1 <= round_avg(w_sum);
    end
  end

  assign bus.average_enable = (r_state == ST_RUN);
  assign bus.acumul_value   = r_acumul_value_p1;
  assign bus.acumul_valid   = r_acumul_valid_p1;
endmodule

// File: tb/tb_sample_averager.sv
// Scoreboard bench for sample_averager with DEBOUNCE_CYCLES = 8, LOG2_N = 4.
module tb_sample_averager;
  import adc_pkg::*;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   cycle;
  int   exp_q[$];
  int   pulse_t[$];

  sample_averager_if bus ();

  sample_averager #(
    .LOG2_N          (4),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // Monitor: every strobe must match the oldest expected average
  always @(negedge clk) begin
    if (rst_n && bus.acumul_valid) begin
      pulse_t.push_back(cycle);
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_valid: got value %0d, no average expected", bus.acumul_value);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (int'(bus.acumul_value) != e) begin
          fails++;
          $display("FAIL avg_value: got %0d, expected %0d", bus.acumul_value, e);
        end
      end
      tests++;
      if (bus.average_enable !== 1'b1) begin
        fails++;
        $display("FAIL enable_with_valid: got %0b, expected 1", bus.average_enable);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int v, input int n);
    for (int i = 0; i < n; i++) begin
      bus.meas_value = 12'(v);
      bus.meas_valid = 1'b1;
      tick(1);
    end
    bus.meas_valid = 1'b0;
    bus.meas_value = '0;
  endtask

  initial begin
    int np;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.avg_sw = 1'b0;
    bus.meas_value = '0;
    bus.meas_valid = 1'b0;
    tick(3);
    check("rst_enable", int'(bus.average_enable), 0);
    check("rst_value", int'(bus.acumul_value), 0);
    check("rst_valid", int'(bus.acumul_valid), 0);
    rst_n = 1'b1;
    tick(2);

    // First average: enable rises together with the strobe
    bus.avg_sw = 1'b1;
    tick(14);
    check("fill_enable", int'(bus.average_enable), 0);
    exp_q.push_back(1000);
    send(1000, 16);
    tick(2);
    check("run_enable", int'(bus.average_enable), 1);
    check("one_pulse", pulse_t.size(), 1);

    // Rounding and full-scale boundaries, back-to-back blocks
    exp_q.push_back(1);
    send(0, 8);
    send(1, 8);
    exp_q.push_back(4095);
    send(4095, 16);
    exp_q.push_back(0);
    send(0, 16);
    tick(2);
    check("boundary_pulses", pulse_t.size(), 4);

    // Short switch glitch is filtered; samples in IDLE are ignored
    bus.avg_sw = 1'b0;
    tick(14);
    check("idle_enable", int'(bus.average_enable), 0);
    bus.avg_sw = 1'b1;
    tick(5);
    bus.avg_sw = 1'b0;
    tick(12);
    send(50, 16);
    tick(2);
    check("glitch_enable", int'(bus.average_enable), 0);
    check("glitch_pulses", pulse_t.size(), 4);

    // Sample presented in the cycle mode_db rises is still in IDLE and dropped
    bus.avg_sw = 1'b1;
    tick(10);
    send(4000, 1);
    exp_q.push_back(16);
    send(16, 15);
    check("fill_no_enable", int'(bus.average_enable), 0);
    send(16, 1);
    tick(2);

    // Switch dropped mid-block: partial sum discarded, value held
    np = pulse_t.size();
    send(700, 10);
    bus.avg_sw = 1'b0;
    tick(14);
    check("drop_enable", int'(bus.average_enable), 0);
    check("drop_hold_value", int'(bus.acumul_value), 16);
    check("drop_no_pulse", pulse_t.size(), np);
    bus.avg_sw = 1'b1;
    tick(14);
    exp_q.push_back(200);
    send(200, 16);
    tick(2);

    // Reset mid-block clears everything
    send(500, 7);
    tick(1);
    rst_n = 1'b0;
    tick(1);
    check("mid_rst_enable", int'(bus.average_enable), 0);
    check("mid_rst_value", int'(bus.acumul_value), 0);
    check("mid_rst_valid", int'(bus.acumul_valid), 0);
    rst_n = 1'b1;
    tick(14);
    exp_q.push_back(300);
    send(300, 16);
    tick(2);

    // Continuous stream: three averages spaced 16 cycles apart
    np = pulse_t.size();
    exp_q.push_back(100);
    exp_q.push_back(100);
    exp_q.push_back(100);
    send(100, 48);
    tick(2);
    check("stream_pulses", pulse_t.size() - np, 3);
    if (pulse_t.size() - np == 3) begin
      check("stream_gap1", pulse_t[np+1] - pulse_t[np], 16);
      check("stream_gap2", pulse_t[np+2] - pulse_t[np+1], 16);
    end

    // Mode falls in the same cycle as the final sample: no average
    np = pulse_t.size();
    send(900, 15);
    bus.avg_sw = 1'b0;
    tick(10);
    send(900, 1);
    tick(3);
    check("late_fall_pulse", pulse_t.size(), np);
    check("late_fall_enable", int'(bus.average_enable), 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sample_averager.md
SAMPLE_AVERAGER -- requirements
Module: sample_averager

Interface
REQ-001 Parameter LOG2_N, default 4, log2 of samples per average (legal 1..6; N = 2^LOG2_N).
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000, consecutive stable cycles required to accept a mode-switch change.
REQ-003 Port clk  input  1  single system clock (PLL output); all logic on rising edge.
REQ-004 Port rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port avg_sw  input  1  raw asynchronous board switch; 1 = averaging mode requested.
REQ-006 Port meas_value  input  12  unsigned ADC conversion result.
REQ-007 Port meas_valid  input  1  one-cycle strobe; meas_value is valid in that cycle.
REQ-008 Port average_enable  output  1  1 = acumul_value holds a valid average and the downstream BCD stage selects it.
REQ-009 Port acumul_value  output  12  latest rounded average.
REQ-010 Port acumul_valid  output  1  one-cycle pulse when acumul_value updates.

Function
REQ-011 avg_sw SHALL pass through a 2-flop synchronizer, then a debouncer; mode_db changes only after the synchronized value differs from mode_db for DEBOUNCE_CYCLES consecutive cycles; any mismatch gap restarts the count.
REQ-012 FSM states: IDLE (mode_db=0), FILL (mode_db=1, no average yet), RUN (mode_db=1, average valid).
REQ-013 IDLE->FILL when mode_db rises; FILL->RUN on first completed average; FILL/RUN->IDLE the cycle after mode_db falls.
REQ-014 In FILL/RUN, each meas_valid cycle: acc += meas_value, cnt += 1; meas_valid ignored in IDLE.
REQ-015 acc width 12+LOG2_N; cnt width LOG2_N; no overflow possible.
REQ-016 On the meas_valid carrying sample N (cnt = N-1): next cycle acumul_value = (acc + sample + 2^(LOG2_N-1)) >> LOG2_N, acumul_valid = 1 for exactly one cycle, acc = 0, cnt = 0; latency 1 cycle.
REQ-017 Rounded result SHALL never exceed 4095; no saturation logic needed.
REQ-018 average_enable = 1 only in RUN; it rises in the same cycle as the first acumul_valid after entering FILL.
REQ-019 Leaving FILL/RUN for IDLE: acc, cnt cleared; average_enable = 0 that cycle; partial sum discarded; no acumul_valid emitted; acumul_value holds last value.
REQ-020 mode_db fall in the same cycle as sample N: the mode change wins; no acumul_valid, acc discarded.
REQ-021 Consecutive meas_valid on back-to-back cycles SHALL be accepted without loss.

Reset
REQ-022 rst_n = 0 at a rising edge: state IDLE, acc = 0, cnt = 0, mode_db = 0, debounce count = 0, synchronizer flops = 0.
REQ-023 Outputs during/after reset: average_enable = 0, acumul_value = 0, acumul_valid = 0.
REQ-024 Reset mid-accumulation discards the partial sum; the next average uses only post-reset samples after the debounce delay.

Structure
REQ-025 Shared package adc_pkg holds ADC_WIDTH = 12, default LOG2_N, default DEBOUNCE_CYCLES, and the FSM state enumeration.
REQ-026 Synchronizer plus debouncer SHALL be one sub-module, switch_debouncer (ports clk, rst_n, sw_raw, sw_db), reusable for other board switches.

Verification (DEBOUNCE_CYCLES = 8, LOG2_N = 4)
REQ-027 avg_sw=1 held, 16 valids of 1000 -> one acumul_valid, acumul_value = 1000, average_enable rises in the same cycle.
REQ-028 Eight 0s then eight 1s -> sum 8, result 1 (round-half-up); 16 samples of 4095 -> 4095; 16 samples of 0 -> 0.
REQ-029 avg_sw pulse high for 5 cycles -> mode_db, average_enable unchanged; high 8+ cycles -> FILL entered 2+8 cycles after the edge.
REQ-030 Switch dropped after sample 10 -> average_enable 0, no acumul_valid; switch restored, 16 samples of 200 -> 200 (no stale sum).
REQ-031 rst_n low 1 cycle after sample 7 of 500 -> all outputs 0; after re-debounce, 16 samples of 300 -> 300.
REQ-032 meas_valid every cycle for 48 cycles -> exactly 3 acumul_valid pulses, 16 cycles apart.
